// File: rtl/fir_out_requant_if.sv
// AXI-Stream style handshake bundle (tdata/tvalid/tready) for the FIR requantiser.
interface fir_out_requant_if #(
  parameter int W = 16
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/fir_out_requant.sv
// Requantises the signed FIR accumulator stream to OUT_W bits (shift, round-half-up, saturate)
// behind an output register plus skid buffer. Optional saturation counter: FIR_REQUANT_STATS_EN.
module fir_out_requant #(
  parameter int IN_W    = 32,
  parameter int OUT_W   = 16,
  parameter int SHIFT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  fir_out_requant_if.slave   s_axis,
  fir_out_requant_if.master  m_axis,
  output logic               m_axis_tsat,
  input  logic [SHIFT_W-1:0] shift_amt,
  output logic [15:0]        sat_count,
  input  logic               clear_stats
);

  localparam logic [SHIFT_W-1:0] SH_MAX  = SHIFT_W'(IN_W - 1);
  localparam logic [IN_W:0]      RND_ONE = (IN_W + 1)'(1);
  localparam logic signed [IN_W:0] SAT_HI = {{(IN_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [IN_W:0] SAT_LO = {{(IN_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

  // One extra bit of headroom so the rounding constant can never wrap the sum.
  function automatic logic signed [IN_W:0] round_shift(input logic signed [IN_W-1:0] d,
                                                       input logic [SHIFT_W-1:0]   sh);
    logic [SHIFT_W-1:0]     sh_c;
    logic [IN_W:0]          rnd;
    logic signed [IN_W:0]   sum;
    sh_c = (sh > SH_MAX) ? SH_MAX : sh;
    rnd  = '0;
    if (sh_c != '0) rnd = RND_ONE << (sh_c - SHIFT_W'(1));
    sum  = $signed({d[IN_W-1], d}) + $signed(rnd);
    return sum >>> sh_c;
  endfunction

  // Returns {sat_flag, sample}.
  function automatic logic [OUT_W:0] saturate(input logic signed [IN_W:0] q);
    logic [OUT_W:0] r;
    if (q > SAT_HI)      r = {1'b1, 1'b0, {(OUT_W - 1){1'b1}}};
    else if (q < SAT_LO) r = {1'b1, 1'b1, {(OUT_W - 1){1'b0}}};
    else                 r = {1'b0, q[OUT_W-1:0]};
    return r;
  endfunction

  // ---- stage p0: combinational requantisation of the offered input sample ----
  logic [OUT_W:0] req_p0;
  logic           accept;
  logic           out_fire;
  logic           out_free;

  assign req_p0 = saturate(round_shift(s_axis.tdata, shift_amt));

  // ---- stage p1: output register and skid register ----
  logic [OUT_W-1:0] data_p1;
  logic             sat_p1;
  logic             vld_p1;
  logic [OUT_W-1:0] skid_data_p1;
  logic             skid_sat_p1;
  logic             skid_vld_p1;

  // tready comes straight from the skid flop, so m_axis.tready never reaches it combinationally.
  assign s_axis.tready = ~skid_vld_p1;
  assign accept        = s_axis.tvalid & ~skid_vld_p1;
  assign out_fire      = vld_p1 & m_axis.tready;
  assign out_free      = ~vld_p1 | m_axis.tready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      data_p1     <= '0;
      sat_p1      <= 1'b0;
    end else if (skid_vld_p1) begin
      if (out_fire) begin
        data_p1     <= skid_data_p1;
        sat_p1      <= skid_sat_p1;
        skid_vld_p1 <= 1'b0;
      end
    end else if (accept) begin
      if (out_free) begin
        data_p1 <= req_p0[OUT_W-1:0];
        sat_p1  <= req_p0[OUT_W];
        vld_p1  <= 1'b1;
      end else begin
        skid_vld_p1 <= 1'b1;
      end
    end else if (out_fire) begin
      vld_p1 <= 1'b0;
    end
  end

  // Skid payload is qualified by skid_vld_p1, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept && !out_free) begin
      skid_data_p1 <= req_p0[OUT_W-1:0];
      skid_sat_p1  <= req_p0[OUT_W];
    end
  end

  assign m_axis.tdata  = data_p1;
  assign m_axis.tvalid = vld_p1;
  assign m_axis_tsat   = sat_p1;

`ifdef FIR_REQUANT_STATS_EN
  logic [15:0] sat_cnt_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_cnt_p1 <= '0;
    end else if (clear_stats) begin
      sat_cnt_p1 <= '0;
    end else if (out_fire && sat_p1 && (sat_cnt_p1 != 16'hFFFF)) begin
      sat_cnt_p1 <= sat_cnt_p1 + 16'd1;
    end
  end

  assign sat_count = sat_cnt_p1;
`else
  logic unused_clear_stats;
  assign unused_clear_stats = clear_stats;
  assign sat_count          = '0;
`endif

endmodule

// File: tb/tb_fir_out_requant.sv
// Directed self-checking bench for fir_out_requant (default build or FIR_REQUANT_STATS_EN).
module tb_fir_out_requant;
  localparam int IN_W    = 32;
  localparam int OUT_W   = 16;
  localparam int SHIFT_W = 5;
`ifdef FIR_REQUANT_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [SHIFT_W-1:0] shift_amt;
  logic               m_axis_tsat;
  logic [15:0]        sat_count;
  logic               clear_stats;

  fir_out_requant_if #(.W(IN_W))  s_if ();
  fir_out_requant_if #(.W(OUT_W)) m_if ();

  fir_out_requant #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .s_axis      (s_if),
    .m_axis      (m_if),
    .m_axis_tsat (m_axis_tsat),
    .shift_amt   (shift_amt),
    .sat_count   (sat_count),
    .clear_stats (clear_stats)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one sample with the sink ready; returns what the output register shows after accept.
  task automatic drive_one(input logic [31:0] d, input logic [4:0] sh,
                           output logic ov, output logic [15:0] od, output logic osat);
    s_if.tdata  = d;
    shift_amt   = sh;
    s_if.tvalid = 1'b1;
    m_if.tready = 1'b1;
    tick();
    s_if.tvalid = 1'b0;
    ov   = m_if.tvalid;
    od   = m_if.tdata;
    osat = m_axis_tsat;
    tick();
  endtask

  task automatic test_reset();
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    m_if.tready = 1'b0;
    shift_amt   = '0;
    clear_stats = 1'b0;
    reset       = 1'b1;
    tick();
    tick();
    checks++;
    if ({s_if.tready, m_if.tvalid, m_axis_tsat} !== 3'b100) begin
      failures++;
      $display("FAIL reset_ctrl: got {s_tready,m_tvalid,tsat}=%b expected 100",
               {s_if.tready, m_if.tvalid, m_axis_tsat});
    end
    checks++;
    if (m_if.tdata !== 16'h0000) begin
      failures++;
      $display("FAIL reset_tdata: got %h expected 0000", m_if.tdata);
    end
    checks++;
    if (sat_count !== 16'h0000) begin
      failures++;
      $display("FAIL reset_sat_count: got %h expected 0000", sat_count);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic ov, osat;
    logic [15:0] od;
    drive_one(32'h0000_1234, 5'd0, ov, od, osat);
    checks++;
    if ({ov, osat, od} !== {1'b1, 1'b0, 16'h1234}) begin
      failures++;
      $display("FAIL basic_pass: got v=%b sat=%b d=%h expected v=1 sat=0 d=1234", ov, osat, od);
    end
    checks++;
    if (m_if.tvalid !== 1'b0) begin
      failures++;
      $display("FAIL basic_drain: got tvalid=%b expected 0", m_if.tvalid);
    end
  endtask

  task automatic test_round();
    logic [31:0] din [6] = '{32'h0000_C000, 32'hFFFF_4000, 32'hFFFF_FFFF,
                             32'h0000_0017, 32'h7FFF_FFFF, 32'h8000_0000};
    logic [4:0]  sh  [6] = '{5'd15, 5'd15, 5'd1, 5'd4, 5'd31, 5'd31};
    logic [15:0] exp [6] = '{16'h0002, 16'hFFFF, 16'h0000, 16'h0001, 16'h0001, 16'hFFFF};
    logic ov, osat;
    logic [15:0] od;
    for (int i = 0; i < 6; i++) begin
      drive_one(din[i], sh[i], ov, od, osat);
      checks++;
      if ({ov, osat, od} !== {1'b1, 1'b0, exp[i]}) begin
        failures++;
        $display("FAIL round_%0d: got v=%b sat=%b d=%h expected v=1 sat=0 d=%h",
                 i, ov, osat, od, exp[i]);
      end
    end
  endtask

  task automatic test_saturate();
    logic [31:0] din  [6] = '{32'h0001_2345, 32'hFFFF_0000, 32'hFFFF_8000,
                              32'h0000_7FFF, 32'h0000_8000, 32'h7FFF_8000};
    logic [4:0]  sh   [6] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd16};
    logic [15:0] exp  [6] = '{16'h7FFF, 16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    logic        esat [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic ov, osat;
    logic [15:0] od;
    for (int i = 0; i < 6; i++) begin
      drive_one(din[i], sh[i], ov, od, osat);
      checks++;
      if ({ov, osat, od} !== {1'b1, esat[i], exp[i]}) begin
        failures++;
        $display("FAIL sat_%0d: got v=%b sat=%b d=%h expected v=1 sat=%b d=%h",
                 i, ov, osat, od, esat[i], exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] got [$];
    int   sent = 0;
    int   acc_at_stall = -1;
    logic rdy_at_stall = 1'b1;
    logic stable_ok = 1'b1;
    logic acc, emit;
    logic [15:0] d;
    shift_amt = 5'd0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      m_if.tready = (cyc >= 3);
      s_if.tvalid = (sent < 4);
      s_if.tdata  = 32'(sent + 1);
      if (cyc == 2) begin
        rdy_at_stall = s_if.tready;
        acc_at_stall = sent;
      end
      if ((cyc == 1) || (cyc == 2))
        stable_ok = stable_ok & (m_if.tvalid === 1'b1) & (m_if.tdata === 16'h0001);
      acc  = s_if.tvalid & s_if.tready;
      emit = m_if.tvalid & m_if.tready;
      d    = m_if.tdata;
      tick();
      if (acc) sent++;
      if (emit) got.push_back(d);
    end
    s_if.tvalid = 1'b0;
    checks++;
    if ({rdy_at_stall, acc_at_stall} !== {1'b0, 32'd2}) begin
      failures++;
      $display("FAIL b2b_backpressure: got s_tready=%b accepted=%0d expected s_tready=0 accepted=2",
               rdy_at_stall, acc_at_stall);
    end
    checks++;
    if (stable_ok !== 1'b1) begin
      failures++;
      $display("FAIL b2b_stall_hold: got stable=%b expected 1", stable_ok);
    end
    checks++;
    if (got.size() != 4) begin
      failures++;
      $display("FAIL b2b_count: got %0d outputs expected 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got[i] !== 16'(i + 1)) begin
          failures++;
          $display("FAIL b2b_order_%0d: got %h expected %h", i, got[i], 16'(i + 1));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    logic [15:0] last = '0;
    m_if.tready = 1'b0;
    shift_amt   = 5'd0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = 32'd10;
    tick();
    s_if.tdata  = 32'd11;
    tick();
    s_if.tvalid = 1'b0;
    checks++;
    if ({m_if.tvalid, s_if.tready} !== 2'b10) begin
      failures++;
      $display("FAIL rst_mid_full: got {m_tvalid,s_tready}=%b expected 10", {m_if.tvalid, s_if.tready});
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({m_if.tvalid, s_if.tready, m_axis_tsat, m_if.tdata} !== {3'b010, 16'h0000}) begin
      failures++;
      $display("FAIL rst_mid_async: got m_tvalid=%b s_tready=%b tsat=%b tdata=%h expected 0 1 0 0000",
               m_if.tvalid, s_if.tready, m_axis_tsat, m_if.tdata);
    end
    tick();
    reset = 1'b0;
    m_if.tready = 1'b1;
    s_if.tdata  = 32'd5;
    s_if.tvalid = 1'b1;
    tick();
    s_if.tvalid = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (m_if.tvalid && m_if.tready) begin
        n++;
        last = m_if.tdata;
      end
      tick();
    end
    checks++;
    if ({n, last} !== {32'd1, 16'h0005}) begin
      failures++;
      $display("FAIL rst_mid_post: got %0d outputs last=%h expected 1 output 0005", n, last);
    end
  endtask

  task automatic test_stats();
    logic ov, osat;
    logic [15:0] od;
    logic [31:0] din [3] = '{32'h0001_2345, 32'hFFFF_0000, 32'h0010_0000};
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    checks++;
    if (sat_count !== 16'h0000) begin
      failures++;
      $display("FAIL stats_clear0: got %h expected 0000", sat_count);
    end
    for (int i = 0; i < 3; i++) drive_one(din[i], 5'd0, ov, od, osat);
    checks++;
    if (sat_count !== 16'(3 * STATS)) begin
      failures++;
      $display("FAIL stats_count: got %h expected %h", sat_count, 16'(3 * STATS));
    end
    // A saturating handshake coincides with clear: the clear must win.
    s_if.tdata  = 32'h0100_0000;
    s_if.tvalid = 1'b1;
    m_if.tready = 1'b1;
    tick();
    s_if.tvalid = 1'b0;
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    checks++;
    if (sat_count !== 16'h0000) begin
      failures++;
      $display("FAIL stats_clear_wins: got %h expected 0000", sat_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
    test_stats();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
